demux_1x2_32: RTL and testbench
===============================

DEMUX_1X2_32 -- requirements
Module: demux_1x2_32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port inData, input, WIDTH bits: the word to be routed.
REQ-005 The block SHALL have port inSel, input, 1 bit: destination, 0 = channel A, 1 = channel B.
REQ-006 The block SHALL have port inValid, input, 1 bit: inData/inSel are valid.
REQ-007 The block SHALL have port inReady, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have port outA, output, WIDTH bits: channel A data register.
REQ-009 The block SHALL have port outAValid, output, 1 bit: outA holds an undelivered word.
REQ-010 The block SHALL have port outAReady, input, 1 bit: the channel A consumer takes the word.
REQ-011 The block SHALL have ports outB, outBValid and outBReady, identical to REQ-008 to REQ-010 but for channel B.
REQ-012 The block SHALL have ports cntA and cntB, output, 16 bits each, present only under DEMUX_COUNT_EN: words accepted per channel.

Function
REQ-013 The block SHALL hold a one-entry buffer per channel (data register plus valid flag); outX and outXValid SHALL be driven directly from it.
REQ-014 inReady SHALL be combinational: (!outAValid | outAReady) when inSel=0; (!outBValid | outBReady) when inSel=1.
REQ-015 A word SHALL be accepted when inValid & inReady; the selected buffer loads inData and its valid flag SHALL be 1 the next cycle (latency 1 cycle).
REQ-016 A word SHALL be delivered when outXValid & outXReady; that buffer's valid flag SHALL clear the next cycle unless a load occurs in the same cycle.
REQ-017 On a simultaneous deliver and load to one channel, the buffer SHALL take the new word and valid SHALL stay 1 (full throughput, 1 word/cycle).
REQ-018 The non-selected channel's buffer and valid flag SHALL be unaffected by an input transfer.
REQ-019 While outXValid=1 and outXReady=0, outX SHALL remain stable.
REQ-020 Both channels SHALL drain independently in the same cycle; a load to one channel SHALL not block a drain of the other.
REQ-021 A word SHALL never be duplicated, dropped or routed to the unselected channel.
REQ-022 inValid=1 with inReady=0 SHALL cause no state change; the upstream side holds the word.

Reset
REQ-023 While rst=1, outAValid and outBValid SHALL be 0, and outA and outB SHALL be 0, regardless of clk.
REQ-024 While rst=1, cntA and cntB (when present) SHALL be 0.
REQ-025 Assertion of rst mid-operation SHALL discard buffered words; the first accepted word after deassertion SHALL appear one cycle after its acceptance.

Configuration
REQ-026 Macro DEMUX_COUNT_EN SHALL control the per-channel counters.
REQ-027 With DEMUX_COUNT_EN defined, cntA and cntB SHALL exist; each SHALL increment by 1 per word accepted for its channel and wrap from 16'hFFFF to 16'h0000.
REQ-028 Without DEMUX_COUNT_EN, the cntA and cntB ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover this scenario: after reset, inSel=0, inData=32'hDEADBEEF, inValid=1 for 1 cycle -> outA=32'hDEADBEEF, outAValid=1 next cycle; outBValid stays 0.
REQ-030 The bench SHALL cover this scenario: outAValid=1, outAReady=0, inSel=0, inValid=1 -> inReady=0; outA holds; after outAReady=1, the new word loads the same cycle and outAValid stays 1.
REQ-031 The bench SHALL cover this scenario: channel A stalled full, inSel=1, inData=32'h00000005 -> inReady=1; outB=32'h5 next cycle; outA unchanged.
REQ-032 The bench SHALL cover this scenario: both ready held 1, alternate inSel 0/1 for 100 words -> each word arrives once on the correct channel in order; with DEMUX_COUNT_EN, cntA=50 and cntB=50.
REQ-033 The bench SHALL cover this scenario: rst pulsed while both buffers are valid -> both valid flags are 0 immediately (asynchronous), and the counters are 0.
REQ-034 The bench SHALL cover this scenario: with DEMUX_COUNT_EN, cntA preset by driving 65536 words to channel A -> cntA wraps to 16'h0000.

Source files
------------

// File: rtl/demux_1x2_32.sv
// demux_1x2_32: routes one input word stream to one of two output channels.
// Each channel has a one-entry buffer (data register plus valid flag) that
// drives its outputs directly. The upstream side gets backpressure only from
// the channel that the current word selects. A channel can drain and reload
// in the same cycle, so each channel sustains one word per cycle.
// Optional feature: define DEMUX_COUNT_EN to add the 16-bit per-channel
// accepted-word counters on ports cntA/cntB.
module demux_1x2_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inData,
  input  logic             inSel,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outA,
  output logic             outAValid,
  input  logic             outAReady,
  output logic [WIDTH-1:0] outB,
  output logic             outBValid,
  input  logic             outBReady
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      cntA,
  output logic [15:0]      cntB
`endif
);

  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic             a_vld_q, a_vld_d;
  logic             b_vld_q, b_vld_d;
  logic             a_room, b_room;
  logic             accept, load_a, load_b;

  // Handshake decode: a channel has room when it is empty or draining this cycle
  always_comb begin
    a_room  = !a_vld_q || outAReady;
    b_room  = !b_vld_q || outBReady;
    inReady = inSel ? b_room : a_room;
    accept  = inValid && inReady;
    load_a  = accept && !inSel;
    load_b  = accept && inSel;
  end

  // Next buffer state: a load wins over a drain, so drain+load keeps valid high
  always_comb begin
    a_data_d = load_a ? inData : a_data_q;
    b_data_d = load_b ? inData : b_data_q;
    a_vld_d  = load_a || (a_vld_q && !outAReady);
    b_vld_d  = load_b || (b_vld_q && !outBReady);
  end

  // Channel buffers; reset clears both data and valid so outputs read zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data_q <= '0;
      b_data_q <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
    end else begin
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
    end
  end

  assign outA      = a_data_q;
  assign outAValid = a_vld_q;
  assign outB      = b_data_q;
  assign outBValid = b_vld_q;

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  // Counter increment per accepted word; natural 16-bit wrap
  always_comb begin
    cnt_a_d = cnt_a_q + {15'd0, load_a};
    cnt_b_d = cnt_b_q + {15'd0, load_b};
  end

  // Accepted-word counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cntA = cnt_a_q;
  assign cntB = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux_1x2_32.sv
// Bench for demux_1x2_32: directed scenarios plus random traffic, all checked
// against a per-channel reference model (buffer occupancy, data, counters) and
// per-channel FIFOs of accepted words that every delivery is matched against.
module tb_demux_1x2_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inData;
  logic        inSel;
  logic        inValid;
  logic        inReady;
  logic [31:0] outA;
  logic        outAValid;
  logic        outAReady;
  logic [31:0] outB;
  logic        outBValid;
  logic        outBReady;
`ifdef DEMUX_COUNT_EN
  logic [15:0] cntA;
  logic [15:0] cntB;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_vld [2];
  logic [31:0] m_dat [2];
  logic [15:0] m_cnt [2];
  logic [31:0] sq_a [$];
  logic [31:0] sq_b [$];

  demux_1x2_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .inData    (inData),
    .inSel     (inSel),
    .inValid   (inValid),
    .inReady   (inReady),
    .outA      (outA),
    .outAValid (outAValid),
    .outAReady (outAReady),
    .outB      (outB),
    .outBValid (outBValid),
    .outBReady (outBReady)
`ifdef DEMUX_COUNT_EN
    ,
    .cntA      (cntA),
    .cntB      (cntB)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_vld[c] = 1'b0;
      m_dat[c] = 32'd0;
      m_cnt[c] = 16'd0;
    end
    sq_a.delete();
    sq_b.delete();
  endtask

  // One clock cycle: compare DUT to model at negedge, then advance the model
  task automatic step();
    logic       ordy [2];
    logic       in_rdy;
    logic       acc;
    logic [31:0] exp_word;
    int         sel;
    @(negedge clk);
    ordy[0] = outAReady;
    ordy[1] = outBReady;
    sel     = inSel ? 1 : 0;
    in_rdy  = !m_vld[sel] || ordy[sel];
    acc     = inValid && in_rdy;
    check("inReady", inReady, in_rdy);
    check("outAValid", outAValid, m_vld[0]);
    check("outA", outA, m_dat[0]);
    check("outBValid", outBValid, m_vld[1]);
    check("outB", outB, m_dat[1]);
`ifdef DEMUX_COUNT_EN
    check("cntA", cntA, m_cnt[0]);
    check("cntB", cntB, m_cnt[1]);
`endif
    // Delivered words must come out once, in order, on the channel they were sent to
    if (outAValid && outAReady) begin
      if (sq_a.size() == 0) check("deliverA_unexpected", 1, 0);
      else begin exp_word = sq_a.pop_front(); check("deliverA", outA, exp_word); end
    end
    if (outBValid && outBReady) begin
      if (sq_b.size() == 0) check("deliverB_unexpected", 1, 0);
      else begin exp_word = sq_b.pop_front(); check("deliverB", outB, exp_word); end
    end
    for (int c = 0; c < 2; c++) begin
      if (acc && sel == c) begin
        m_vld[c] = 1'b1;
        m_dat[c] = inData;
        m_cnt[c] = m_cnt[c] + 16'd1;
      end else if (m_vld[c] && ordy[c]) begin
        m_vld[c] = 1'b0;
      end
    end
    if (acc) begin
      if (sel == 0) sq_a.push_back(inData);
      else          sq_b.push_back(inData);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inData = '0; inSel = 1'b0; inValid = 1'b0;
    outAReady = 1'b0; outBReady = 1'b0;
    model_reset();

    // Reset state, before any clock edge
    #3;
    check("rst_outAValid", outAValid, 0);
    check("rst_outBValid", outBValid, 0);
    check("rst_outA", outA, 0);
    check("rst_outB", outB, 0);
`ifdef DEMUX_COUNT_EN
    check("rst_cntA", cntA, 0);
    check("rst_cntB", cntB, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word to channel A
    inSel = 1'b0; inData = 32'hDEADBEEF; inValid = 1'b1;
    step();
    inValid = 1'b0;
    step();
    check("s1_outA", outA, 32'hDEADBEEF);
    check("s1_outAValid", outAValid, 1);
    check("s1_outBValid", outBValid, 0);

    // Channel A stalled: upstream held off, outA stable
    inSel = 1'b0; inData = 32'h11111111; inValid = 1'b1;
    repeat (3) step();
    check("s2_outA_hold", outA, 32'hDEADBEEF);
    outAReady = 1'b1;
    step();
    inValid = 1'b0; outAReady = 1'b0;
    step();
    check("s2_outA_new", outA, 32'h11111111);
    check("s2_outAValid", outAValid, 1);

    // A still full and stalled; channel B accepts independently
    inSel = 1'b1; inData = 32'h00000005; inValid = 1'b1;
    step();
    inValid = 1'b0;
    step();
    check("s3_outB", outB, 32'h5);
    check("s3_outA_unch", outA, 32'h11111111);

    // Asynchronous reset with both buffers valid
    #1 rst = 1'b1;
    #1;
    check("arst_outAValid", outAValid, 0);
    check("arst_outBValid", outBValid, 0);
    check("arst_outA", outA, 0);
`ifdef DEMUX_COUNT_EN
    check("arst_cntA", cntA, 0);
    check("arst_cntB", cntB, 0);
`endif
    #1 rst = 1'b0;
    model_reset();
    step();

    // 100 alternating words, both consumers always ready
    outAReady = 1'b1; outBReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      inSel = i[0]; inData = $urandom; inValid = 1'b1;
      step();
    end
    inValid = 1'b0;
    repeat (2) step();
    check("alt_qA_empty", sq_a.size(), 0);
    check("alt_qB_empty", sq_b.size(), 0);
`ifdef DEMUX_COUNT_EN
    check("alt_cntA", cntA, 50);
    check("alt_cntB", cntB, 50);
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      inValid = ($urandom_range(0, 3) != 0);
      inSel = $urandom_range(0, 1);
      inData = $urandom;
      outAReady = ($urandom_range(0, 2) != 0);
      outBReady = ($urandom_range(0, 2) != 0);
      step();
    end
    inValid = 1'b0; outAReady = 1'b1; outBReady = 1'b1;
    repeat (3) step();
    check("rnd_qA_empty", sq_a.size(), 0);
    check("rnd_qB_empty", sq_b.size(), 0);

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 65536 words into channel A after a reset
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    step();
    outAReady = 1'b1; inSel = 1'b0; inValid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      inData = $urandom;
      step();
    end
    inValid = 1'b0;
    step();
    check("wrap_cntA", cntA, 16'h0000);
    check("wrap_cntB", cntB, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
